mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single main-memory port behind the cache controllers. It serialises read-miss refills and write-through writes from two cache controllers, for example instruction-side and data-side. For each granted transaction it drives the existing memory handshake: `mem_rd_en`/`mem_data_valid` for reads and `mem_wd_en`/`mem_wd_valid` for writes. It returns read data and a one-cycle completion pulse to the owning requester. Fairness is round-robin.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer putting two cache controllers onto one memory port.
// Optional BUSY watchdog enabled by defining MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_rd_en,
  input  logic              c0_wr_en,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wr_data,
  input  logic              c1_rd_en,
  input  logic              c1_wr_en,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wr_data,
  output logic              c0_gnt,
  output logic              c1_gnt,
  output logic              c0_done,
  output logic              c1_done,
  output logic              c0_err,
  output logic              c1_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_rd_en,
  output logic              mem_wd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_data_valid,
  input  logic              mem_wd_valid,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic              last;
  logic              owner;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;

  logic p0, p1, win, win_wr, hit, expire, finish;

  assign p0     = c0_rd_en | c0_wr_en;
  assign p1     = c1_rd_en | c1_wr_en;
  // c1 wins when alone, or on a tie when c0 was the last winner
  assign win    = p1 & (~p0 | ~last);
  assign win_wr = win ? c1_wr_en : c0_wr_en;
  assign hit    = lat_wr ? mem_wd_valid : mem_data_valid;
  assign finish = hit | expire;

  assign mem_addr    = lat_addr;
  assign mem_wd_data = lat_data;
  assign busy        = (state != IDLE);

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  assign expire = (cnt == 16'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
  assign c0_err = 1'b0;
  assign c1_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      c0_gnt    <= 1'b0;
      c1_gnt    <= 1'b0;
      c0_done   <= 1'b0;
      c1_done   <= 1'b0;
      rd_data   <= '0;
      mem_rd_en <= 1'b0;
      mem_wd_en <= 1'b0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
      cnt       <= '0;
      c0_err    <= 1'b0;
      c1_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (p0 | p1) begin
            owner     <= win;
            lat_wr    <= win_wr;
            lat_addr  <= win ? c1_addr : c0_addr;
            lat_data  <= win ? c1_wr_data : c0_wr_data;
            c0_gnt    <= ~win;
            c1_gnt    <= win;
            mem_rd_en <= ~win_wr;
            mem_wd_en <= win_wr;
            state     <= BUSY;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
            cnt       <= '0;
`endif
          end
        end
        BUSY: begin
          if (finish) begin
            mem_rd_en <= 1'b0;
            mem_wd_en <= 1'b0;
            c0_done   <= ~owner;
            c1_done   <= owner;
            last      <= owner;
            state     <= RESP;
            // a valid coinciding with the limit completes normally
            if (!hit)
              rd_data <= '0;
            else if (!lat_wr)
              rd_data <= mem_data;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
            c0_err    <= ~hit & ~owner;
            c1_err    <= ~hit & owner;
`endif
          end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
          else begin
            cnt <= cnt + 16'd1;
          end
`endif
        end
        RESP: begin
          c0_done <= 1'b0;
          c1_done <= 1'b0;
          c0_gnt  <= 1'b0;
          c1_gnt  <= 1'b0;
          state   <= IDLE;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
          c0_err  <= 1'b0;
          c1_err  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected transactions,
// a negedge monitor checks strobes, grants and completions against them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_rd_en, c0_wr_en, c1_rd_en, c1_wr_en;
  logic [31:0] c0_addr, c1_addr;
  logic [63:0] c0_wr_data, c1_wr_data;
  logic        c0_gnt, c1_gnt, c0_done, c1_done, c0_err, c1_err;
  logic [63:0] rd_data;
  logic        mem_rd_en, mem_wd_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_wd_data, mem_data;
  logic        mem_data_valid, mem_wd_valid;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .c0_rd_en(c0_rd_en), .c0_wr_en(c0_wr_en), .c0_addr(c0_addr), .c0_wr_data(c0_wr_data),
    .c1_rd_en(c1_rd_en), .c1_wr_en(c1_wr_en), .c1_addr(c1_addr), .c1_wr_data(c1_wr_data),
    .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_done(c0_done), .c1_done(c1_done),
    .c0_err(c0_err), .c1_err(c1_err), .rd_data(rd_data),
    .mem_rd_en(mem_rd_en), .mem_wd_en(mem_wd_en), .mem_addr(mem_addr),
    .mem_wd_data(mem_wd_data), .mem_data(mem_data),
    .mem_data_valid(mem_data_valid), .mem_wd_valid(mem_wd_valid), .busy(busy)
  );

  typedef struct {
    bit          id;
    bit          wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    bit          err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int          mem_lat = -1;
  bit          stray = 1'b0;
  logic [63:0] mem_rdata = '0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(bit id, bit wr, logic [31:0] a, logic [63:0] wd,
                              logic [63:0] rd, bit err);
    exp_t e;
    e.id = id; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd; e.err = err;
    return e;
  endfunction

  // Memory model: responds mem_lat cycles after the first strobe cycle (-1 = never)
  initial begin
    int bc;
    bc = 0;
    mem_data_valid = 1'b0;
    mem_wd_valid   = 1'b0;
    mem_data       = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_rd_en | mem_wd_en) bc++;
      else bc = 0;
      mem_data       = mem_rdata;
      mem_data_valid = (mem_rd_en && mem_lat >= 0 && bc == mem_lat + 1) ||
                       (stray && mem_wd_en && bc == 1);
      mem_wd_valid   = mem_wd_en && mem_lat >= 0 && bc == mem_lat + 1;
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (c0_gnt | c1_gnt) chk("single_gnt", {63'd0, c0_gnt & c1_gnt}, 64'd0);
        if (mem_rd_en | mem_wd_en) begin
          if (q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL strobe_unexpected: got strobe, expected none at %0t", $time);
          end else begin
            e = q[0];
            chk("strobe_gnt", {63'd0, e.id ? c1_gnt : c0_gnt}, 64'd1);
            chk("strobe_type", {62'd0, mem_wd_en, mem_rd_en}, {62'd0, e.wr, ~e.wr});
            chk("mem_addr", {32'd0, mem_addr}, {32'd0, e.addr});
            if (e.wr) chk("mem_wd_data", mem_wd_data, e.wdata);
          end
        end
        if (c0_done | c1_done) begin
          if (q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL done_unexpected: got done, expected none at %0t", $time);
          end else begin
            e = q.pop_front();
            chk("done_owner", {62'd0, c1_done, c0_done}, {62'd0, e.id, ~e.id});
            chk("done_gnt", {63'd0, e.id ? c1_gnt : c0_gnt}, 64'd1);
            chk("done_strobe", {62'd0, mem_rd_en, mem_wd_en}, 64'd0);
            chk("rd_data", rd_data, e.rdata);
            chk("err", {62'd0, c1_err, c0_err}, {62'd0, e.err & e.id, e.err & ~e.id});
          end
        end
      end
    end
  end

  task automatic set_req(input bit id, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [63:0] d);
    if (id) begin
      c1_rd_en = rd; c1_wr_en = wr; c1_addr = a; c1_wr_data = d;
    end else begin
      c0_rd_en = rd; c0_wr_en = wr; c0_addr = a; c0_wr_data = d;
    end
  endtask

  task automatic do_req(input bit id, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [63:0] d, input int n, output int t);
    bit seen;
    t = 0;
    set_req(id, rd, wr, a, d);
    for (int k = 0; k < n; k++) begin
      t = 0;
      seen = 1'b0;
      while (!seen && t < 200) begin
        @(posedge clk);
        #1;
        t++;
        seen = id ? c1_done : c0_done;
      end
      if (!seen) chk("req_wait_expired", 64'd0, 64'd1);
    end
    set_req(id, 1'b0, 1'b0, a, d);
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_gnt"},  {62'd0, c1_gnt, c0_gnt}, 64'd0);
    chk({nm, "_done"}, {62'd0, c1_done, c0_done}, 64'd0);
    chk({nm, "_err"},  {62'd0, c1_err, c0_err}, 64'd0);
    chk({nm, "_strb"}, {62'd0, mem_rd_en, mem_wd_en}, 64'd0);
    chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
    chk({nm, "_rd_data"}, rd_data, 64'd0);
    chk({nm, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
    chk({nm, "_mem_wd_data"}, mem_wd_data, 64'd0);
  endtask

  initial begin
    int t, t0, t1;
    bit seen;
    rst = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Tie from reset: c0 first, then strict alternation, 3-cycle period
    mem_lat   = 0;
    mem_rdata = 64'h1111_2222_3333_4444;
    q.push_back(mk(1'b0, 1'b0, 32'h0000_0100, 64'd0, 64'h1111_2222_3333_4444, 1'b0));
    q.push_back(mk(1'b1, 1'b1, 32'h0000_0200, {4{16'hAAAA}}, 64'h1111_2222_3333_4444, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 32'h0000_0100, 64'd0, 64'h1111_2222_3333_4444, 1'b0));
    q.push_back(mk(1'b1, 1'b1, 32'h0000_0200, {4{16'hAAAA}}, 64'h1111_2222_3333_4444, 1'b0));
    fork
      do_req(1'b0, 1'b1, 1'b0, 32'h0000_0100, 64'd0, 2, t0);
      do_req(1'b1, 1'b0, 1'b1, 32'h0000_0200, {4{16'hAAAA}}, 2, t1);
    join
    // c1 waits out one c0 transaction (3 cycles) before each of its own
    chk("pair_c1_last_wait", t1, 6);
    repeat (2) @(posedge clk);
    #1;

    // Single c0 read, valid 3 cycles after strobe
    mem_lat   = 3;
    mem_rdata = 64'hDEAD_BEEF_0123_4567;
    q.push_back(mk(1'b0, 1'b0, 32'h0000_1008, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0));
    do_req(1'b0, 1'b1, 1'b0, 32'h0000_1008, 64'd0, 1, t);
    chk("read_latency", t, 5);
    @(posedge clk);
    #1;

    // c1 write with a stray read-valid in BUSY; rd_data must not move
    mem_lat   = 2;
    stray     = 1'b1;
    mem_rdata = 64'hBADB_ADBA_DBAD_BAD0;
    q.push_back(mk(1'b1, 1'b1, 32'h0020_0000, {4{16'h5555}}, 64'hDEAD_BEEF_0123_4567, 1'b0));
    do_req(1'b1, 1'b1, 1'b1, 32'h0020_0000, {4{16'h5555}}, 1, t);
    chk("write_latency", t, 4);
    stray = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a c1 read that memory never answers
    mem_lat = -1;
    q.push_back(mk(1'b1, 1'b0, 32'h0000_0300, 64'd0, 64'd0, 1'b0));
    set_req(1'b1, 1'b1, 1'b0, 32'h0000_0300, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_busy", {62'd0, busy, c1_gnt}, 64'd3);
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    q.delete();
    mem_lat   = 0;
    mem_rdata = 64'h0F0F_0F0F_0F0F_0F0F;
    q.push_back(mk(1'b1, 1'b0, 32'h0000_0300, 64'd0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("post_reset_idle_gnt", {63'd0, c1_gnt}, 64'd0);
    @(posedge clk);
    #1;
    chk("post_reset_regrant", {62'd0, c1_gnt, c0_gnt}, 64'd2);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = c1_done;
    end
    if (!seen) chk("regrant_done_expired", 64'd0, 64'd1);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    mem_lat = -1;
    q.push_back(mk(1'b0, 1'b0, 32'h0000_0400, 64'd0, 64'd0, 1'b1));
    do_req(1'b0, 1'b1, 1'b0, 32'h0000_0400, 64'd0, 1, t);
    chk("timeout_latency", t, 9);
    repeat (2) @(posedge clk);
    #1;
`else
    mem_lat = -1;
    q.push_back(mk(1'b0, 1'b0, 32'h0000_0400, 64'd0, 64'd0, 1'b0));
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_0400, 64'd0);
    for (int k = 0; k < 10; k++) begin
      repeat (100) @(posedge clk);
      #1;
      chk("stuck_busy", {63'd0, busy}, 64'd1);
    end
    rst = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    q.delete();
    #5;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("recover_idle", {63'd0, busy}, 64'd0);
`endif

    chk("scoreboard_drained", q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
